mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
- Copy engine that sits directly upstream of the team's `memory` block instances.
- Reads a contiguous block of words from a source memory (ROM instance, `IS_RAM=0`) and writes it into a destination memory (RAM instance, `IS_RAM=1`).
- Pipelined: one word issued per cycle, tolerating a fixed source read latency.
- Used to initialise RAM from ROM images after reset, under control of a start/done handshake.

Parameters:
- DATA_WIDTH, 8, word width; matches the memory DATA_WIDTH.
- ADDR_WIDTH, 8, address width of both memories; addresses wrap modulo 2^ADDR_WIDTH.
- RD_LAT, 1, source read latency in cycles, range 1..4.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_base  in  ADDR_WIDTH  first source address; latched on accepted start.
- dst_base  in  ADDR_WIDTH  first destination address; latched on accepted start.
- len  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last write.
- src_addr  out  ADDR_WIDTH  registered address to the source memory `addr`.
- src_data  in  DATA_WIDTH  source memory `data_out`.
- dst_addr  out  ADDR_WIDTH  registered address to the destination memory `addr`.
- dst_data  out  DATA_WIDTH  registered destination memory `data_in`.
- dst_we  out  1  registered destination memory `we`.

Behaviour:
- Reset, synchronous, applied on any cycle including mid-copy:
  - state=IDLE; busy, done, dst_we = 0.
  - src_addr, dst_addr, dst_data = 0.
  - valid pipeline cleared, so no write issues after reset.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 and len!=0: latch bases and len, rd_cnt=0, go to RUN.
  - start=1 and len==0: go to DONE, no writes.
  - start while not IDLE is ignored, with no queueing.
- RUN:
  - Each cycle drives src_addr = src_base+rd_cnt (mod 2^ADDR_WIDTH).
  - Pushes a valid bit with tag wr_idx=rd_cnt into a RD_LAT-deep delay line, then increments rd_cnt.
  - After issuing word len-1, go to DRAIN.
- Source timing contract: src_data for the src_addr driven in cycle k is valid in cycle k+RD_LAT.
- Write path, when the delay line output is valid in cycle k+RD_LAT:
  - Capture src_data.
  - In cycle k+RD_LAT+1 drive dst_we=1, dst_addr = dst_base+wr_idx (mod 2^ADDR_WIDTH), dst_data = captured word.
  - When not writing, dst_we=0 and dst_addr/dst_data hold their previous values.
- DRAIN:
  - src_addr holds its last value.
  - When the final write is issued (dst_we=1 for word len-1), go to DONE on the next edge.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Throughput and latency:
  - One word per cycle.
  - With `start` accepted at edge 0, the first dst_we is high in cycle RD_LAT+2 and the last in cycle len+RD_LAT+1.
  - done is high in cycle len+RD_LAT+2.
- Counters:
  - rd_cnt and the wr_idx tags are ADDR_WIDTH+1 bits so len = 2^ADDR_WIDTH completes.
  - Address adds truncate to ADDR_WIDTH.
- Overlapping source and destination address ranges are permitted; the engine does not detect them, since the source and destination memories are separate.

Optional Feature:
- Macro: MEM_COPY_CHECKSUM_EN.
- Defined:
  - Adds output port `checksum` [DATA_WIDTH-1:0].
  - Running sum mod 2^DATA_WIDTH of every word written with dst_we=1.
  - Cleared to 0 on reset and on accepted start; stable and valid from the done cycle until the next accepted start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package mem_copy_pkg:
  - State enum (IDLE, RUN, DRAIN, DONE).
  - Default width constants, and RD_LAT_MAX = 4.
- Sub-module mem_copy_vpipe:
  - Parameterised delay line of RD_LAT stages, each carrying {valid, wr_idx}.
  - Synchronous clear on rst.
  - Instantiated once in mem_copy_engine.

Test Plan:
- Basic copy: bench ROM mem[i]=i^8'hA5; RD_LAT=1; start with src_base=0, dst_base=8'h10, len=3.
  - dst_we high in cycles 3..5 writing 10:A5, 11:A4, 12:A7.
  - done in cycle 6; RAM readback matches.
- len=0: start -> done pulse the next cycle, dst_we never asserts, busy never asserts.
- Wrap-around: src_base=8'hFE, dst_base=8'hFF, len=4.
  - Source addresses FE, FF, 00, 01.
  - Writes to FF, 00, 01, 02 with data 5B, 5A, A5, A4.
- Full depth with RD_LAT=3: len=256 -> exactly 256 writes, done in cycle 261, all RAM locations match the ROM.
- Busy and reset:
  - start re-asserted during RUN is ignored.
  - rst asserted mid-RUN -> next cycle busy=0 and dst_we=0; no writes after reset; a fresh start then copies correctly.
- MEM_COPY_CHECKSUM_EN defined, basic copy above -> checksum = A5+A4+A7 mod 256 = 8'hF0 at done.

Source files
------------

// File: rtl/mem_copy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_copy_pkg
//  Description : Shared types and default constants for the memory copy
//                engine (state encoding, default widths, read-latency cap).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_copy_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_RD_LAT     = 1;
    localparam int RD_LAT_MAX     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_copy_vpipe.sv
`default_nettype none
// ============================================================================
//  Module      : mem_copy_vpipe
//  Description : Delay line of DEPTH stages carrying {valid, write index}.
//                Matches the source memory read latency so the tag emerges
//                in the same cycle as the data it describes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_vpipe #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    logic [DEPTH-1:0] r_valid;
    logic [IDX_W-1:0] r_idx [DEPTH];

    // Shift valid and tag one stage per cycle; reset flushes every stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_idx[i] <= '0;
            end
        end else begin
            r_valid[0] <= in_valid;
            r_idx[0]   <= in_idx;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_idx[i]   <= r_idx[i-1];
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_idx   = r_idx[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : mem_copy_engine
//  Description : Pipelined block copy from a source memory (fixed read
//                latency RD_LAT) into a destination memory, one word per
//                cycle, with a start/busy/done handshake.
//                Optional macro MEM_COPY_CHECKSUM_EN adds a `checksum`
//                output holding the mod-2^DATA_WIDTH sum of written words.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RD_LAT     = DEF_RD_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic [ADDR_WIDTH-1:0] dst_addr,
    output logic [DATA_WIDTH-1:0] dst_data,
    output logic                  dst_we
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    // Counters are one bit wider than an address so a full 2^ADDR_WIDTH
    // block can be counted without the length aliasing to zero.
    localparam int CW = ADDR_WIDTH + 1;

    // Out-of-range latencies are clamped to the supported window.
    localparam int C_LAT = (RD_LAT < 1) ? 1 :
                           ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);

    localparam logic [1:0] C_ST_IDLE  = ST_IDLE;
    localparam logic [1:0] C_ST_RUN   = ST_RUN;
    localparam logic [1:0] C_ST_DRAIN = ST_DRAIN;
    localparam logic [1:0] C_ST_DONE  = ST_DONE;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_src_base;
    logic [ADDR_WIDTH-1:0] r_dst_base;
    logic [CW-1:0]         r_len;
    logic [CW-1:0]         r_rd_cnt;
    logic                  r_last_wr;

    logic                  w_accept;
    logic                  w_issue;
    logic                  w_last_issue;
    logic [CW-1:0]         w_next_cnt;
    logic                  w_pv;
    logic [CW-1:0]         w_pidx;

    assign w_accept     = (r_state == C_ST_IDLE) && start;
    assign w_issue      = (r_state == C_ST_RUN);
    assign w_last_issue = w_issue && (r_rd_cnt == (r_len - CW'(1)));
    assign w_next_cnt   = r_rd_cnt + CW'(1);

    assign busy = (r_state == C_ST_RUN) || (r_state == C_ST_DRAIN);
    assign done = (r_state == C_ST_DONE);

    // Tag pipeline: the word issued this cycle reappears when its data lands
    mem_copy_vpipe #(
        .DEPTH (C_LAT),
        .IDX_W (CW)
    ) u_vpipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_issue),
        .in_idx    (r_rd_cnt),
        .out_valid (w_pv),
        .out_idx   (w_pidx)
    );

    // Control FSM and read-side addressing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= C_ST_IDLE;
            r_src_base <= '0;
            r_dst_base <= '0;
            r_len      <= '0;
            r_rd_cnt   <= '0;
            src_addr   <= '0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            r_src_base <= src_base;
                            r_dst_base <= dst_base;
                            r_len      <= len;
                            r_rd_cnt   <= '0;
                            // First read address goes out in the first RUN cycle
                            src_addr   <= src_base;
                            r_state    <= C_ST_RUN;
                        end else begin
                            r_state    <= C_ST_DONE;
                        end
                    end
                end
                C_ST_RUN: begin
                    r_rd_cnt <= w_next_cnt;
                    if (w_last_issue) begin
                        // src_addr stays on the final word while draining
                        r_state <= C_ST_DRAIN;
                    end else begin
                        src_addr <= r_src_base + w_next_cnt[ADDR_WIDTH-1:0];
                    end
                end
                C_ST_DRAIN: begin
                    if (dst_we && r_last_wr) begin
                        r_state <= C_ST_DONE;
                    end
                end
                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

    // Write side: capture returning data and present it one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            dst_we    <= 1'b0;
            dst_addr  <= '0;
            dst_data  <= '0;
            r_last_wr <= 1'b0;
        end else begin
            dst_we    <= w_pv;
            r_last_wr <= w_pv && (w_pidx == (r_len - CW'(1)));
            if (w_pv) begin
                dst_addr <= r_dst_base + w_pidx[ADDR_WIDTH-1:0];
                dst_data <= src_data;
            end
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    // Running sum of every word actually written, restarted per copy
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            checksum <= '0;
        end else if (dst_we) begin
            checksum <= checksum + dst_data;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_copy_engine
//  Description : Self-checking bench for mem_copy_engine. Two instances run
//                side by side (RD_LAT=1 and RD_LAT=3) against behavioural
//                ROM (mem[i]=i^A5) and RAM models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_copy_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] src_base;
    logic [7:0] dst_base;
    logic [8:0] len;

    logic [1:0] busy_v;
    logic [1:0] done_v;
    logic [1:0] we_v;
    logic [7:0] src_addr_v [2];
    logic [7:0] src_data_v [2];
    logic [7:0] dst_addr_v [2];
    logic [7:0] dst_data_v [2];
`ifdef MEM_COPY_CHECKSUM_EN
    logic [7:0] cks_v [2];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_copy_engine #(
            .DATA_WIDTH (8),
            .ADDR_WIDTH (8),
            .RD_LAT     ((g == 0) ? 1 : 3)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start),
            .src_base (src_base),
            .dst_base (dst_base),
            .len      (len),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .src_addr (src_addr_v[g]),
            .src_data (src_data_v[g]),
            .dst_addr (dst_addr_v[g]),
            .dst_data (dst_data_v[g]),
            .dst_we   (we_v[g])
`ifdef MEM_COPY_CHECKSUM_EN
            ,
            .checksum (cks_v[g])
`endif
        );
    end

    // ROM model: contents i^A5, read latency 1 (instance 0) or 3 (instance 1)
    logic [7:0] rom_sh [2][3];
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            rom_sh[g][0] <= src_addr_v[g] ^ 8'hA5;
            rom_sh[g][1] <= rom_sh[g][0];
            rom_sh[g][2] <= rom_sh[g][1];
        end
    end
    assign src_data_v[0] = rom_sh[0][0];
    assign src_data_v[1] = rom_sh[1][2];

    // RAM model
    logic [7:0] ram [2][256];
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (we_v[g]) ram[g][dst_addr_v[g]] <= dst_data_v[g];
        end
    end

    // Per-run observations, filled by run_copy
    int         nwr     [2];
    int         first_c [2];
    int         last_c  [2];
    int         done_c  [2];
    int         busy_c  [2];
    int         bad     [2];
    logic [7:0] cks_done[2];
    logic [7:0] src_tr  [2][4];

    typedef struct {
        logic [7:0]       src;
        logic [7:0]       dst;
        logic [8:0]       len;
        logic [1:0][8:0]  first;
        logic [1:0][8:0]  last;
        logic [1:0][8:0]  done_at;
        logic [7:0]       cks;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] s, input logic [7:0] d, input logic [8:0] n,
                                input int f1, input int l1, input int d1,
                                input int f3, input int l3, input int d3,
                                input logic [7:0] ck);
        vec_t v;
        v.src = s; v.dst = d; v.len = n;
        v.first[0] = 9'(f1); v.last[0] = 9'(l1); v.done_at[0] = 9'(d1);
        v.first[1] = 9'(f3); v.last[1] = 9'(l3); v.done_at[1] = 9'(d3);
        v.cks = ck;
        return v;
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input int g, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (RD_LAT=%0d): got 0x%0h, want 0x%0h", name, lat_of(g), act, exp);
        end
    endtask

    // Start a copy in cycle 0 and observe both instances until both report
    // done or the cycle budget expires. A second start can be injected at
    // cycle restart_c (0 = none) to probe that it is ignored.
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [8:0] n,
                            input int restart_c);
        int budget;
        logic [7:0] ea, ed;
        budget = int'(n) + 20;
        for (int g = 0; g < 2; g++) begin
            nwr[g] = 0; first_c[g] = 0; last_c[g] = 0; done_c[g] = 0;
            busy_c[g] = 0; bad[g] = 0; cks_done[g] = 8'h00;
            for (int k = 0; k < 4; k++) src_tr[g][k] = 8'h00;
        end
        @(negedge clk);
        src_base = s; dst_base = d; len = n; start = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start = 1'b0;
            for (int g = 0; g < 2; g++) begin
                if (c <= 4) src_tr[g][c-1] = src_addr_v[g];
                if (we_v[g]) begin
                    if (nwr[g] == 0) first_c[g] = c;
                    last_c[g] = c;
                    ea = d + 8'(nwr[g]);
                    ed = (s + 8'(nwr[g])) ^ 8'hA5;
                    if (dst_addr_v[g] != ea || dst_data_v[g] != ed) bad[g]++;
                    nwr[g]++;
                end
                if (busy_v[g]) busy_c[g]++;
                if (done_v[g] && done_c[g] == 0) begin
                    done_c[g] = c;
`ifdef MEM_COPY_CHECKSUM_EN
                    cks_done[g] = cks_v[g];
`endif
                end
            end
            if (c == restart_c) begin
                start = 1'b1; src_base = 8'h00; dst_base = 8'h00; len = 9'd2;
            end
            if (done_c[0] != 0 && done_c[1] != 0) break;
        end
        start = 1'b0;
    endtask

    task automatic check_run(input int g, input int n, input int f, input int l, input int d);
        check("write_count", g, nwr[g], n);
        check("first_we_cycle", g, first_c[g], f);
        check("last_we_cycle", g, last_c[g], l);
        check("done_cycle", g, done_c[g], d);
        check("busy_cycles", g, busy_c[g], (n == 0) ? 0 : d - 1);
        check("write_addr_data_errors", g, bad[g], 0);
    endtask

    vec_t vec [4];

    initial begin
        int cnt [2];

        vec[0] = mk(8'h00, 8'h10, 9'd3,   3, 5,   6,   5, 7,   8,   8'hF0);
        vec[1] = mk(8'h05, 8'h20, 9'd0,   0, 0,   1,   0, 0,   1,   8'h00);
        vec[2] = mk(8'hFE, 8'hFF, 9'd4,   3, 6,   7,   5, 8,   9,   8'hFE);
        vec[3] = mk(8'h00, 8'h00, 9'd256, 3, 258, 259, 5, 260, 261, 8'h80);

        rst = 1'b1; start = 1'b0; src_base = 8'h00; dst_base = 8'h00; len = 9'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("reset_busy", g, int'(busy_v[g]), 0);
            check("reset_done", g, int'(done_v[g]), 0);
            check("reset_dst_we", g, int'(we_v[g]), 0);
            check("reset_src_addr", g, int'(src_addr_v[g]), 0);
            check("reset_dst_addr", g, int'(dst_addr_v[g]), 0);
            check("reset_dst_data", g, int'(dst_data_v[g]), 0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven copies
        for (int i = 0; i < 4; i++) begin
            run_copy(vec[i].src, vec[i].dst, vec[i].len, 0);
            for (int g = 0; g < 2; g++) begin
                check_run(g, int'(vec[i].len), int'(vec[i].first[g]),
                          int'(vec[i].last[g]), int'(vec[i].done_at[g]));
`ifdef MEM_COPY_CHECKSUM_EN
                check("checksum_at_done", g, int'(cks_done[g]), int'(vec[i].cks));
`endif
                if (i == 0) begin
                    check("ram_10", g, int'(ram[g][8'h10]), 8'hA5);
                    check("ram_11", g, int'(ram[g][8'h11]), 8'hA4);
                    check("ram_12", g, int'(ram[g][8'h12]), 8'hA7);
                end
                if (i == 2) begin
                    check("wrap_src_0", g, int'(src_tr[g][0]), 8'hFE);
                    check("wrap_src_1", g, int'(src_tr[g][1]), 8'hFF);
                    check("wrap_src_2", g, int'(src_tr[g][2]), 8'h00);
                    check("wrap_src_3", g, int'(src_tr[g][3]), 8'h01);
                    check("ram_FF", g, int'(ram[g][8'hFF]), 8'h5B);
                    check("ram_00", g, int'(ram[g][8'h00]), 8'h5A);
                    check("ram_01", g, int'(ram[g][8'h01]), 8'hA5);
                    check("ram_02", g, int'(ram[g][8'h02]), 8'hA4);
                end
                if (i == 3) begin
                    cnt[g] = 0;
                    for (int a = 0; a < 256; a++) begin
                        if (ram[g][a] != (8'(a) ^ 8'hA5)) cnt[g]++;
                    end
                    check("full_ram_mismatches", g, cnt[g], 0);
                end
            end
            repeat (2) @(negedge clk);
        end

        // Start re-asserted during RUN must be ignored (no queued second copy)
        run_copy(8'h40, 8'h80, 9'd5, 2);
        check_run(0, 5, 3, 7, 8);
        check_run(1, 5, 5, 9, 10);
        cnt[0] = 0; cnt[1] = 0;
        repeat (8) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) if (busy_v[g] || we_v[g] || done_v[g]) cnt[g]++;
        end
        for (int g = 0; g < 2; g++) check("activity_after_ignored_start", g, cnt[g], 0);

        // Reset in the middle of a copy
        @(negedge clk);
        src_base = 8'h00; dst_base = 8'h30; len = 9'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        for (int g = 0; g < 2; g++) check("busy_before_reset", g, int'(busy_v[g]), 1);
        rst = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("busy_after_reset", g, int'(busy_v[g]), 0);
            check("we_after_reset", g, int'(we_v[g]), 0);
            check("done_after_reset", g, int'(done_v[g]), 0);
        end
        rst = 1'b0;
        cnt[0] = 0; cnt[1] = 0;
        repeat (12) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) if (we_v[g] || busy_v[g]) cnt[g]++;
        end
        for (int g = 0; g < 2; g++) check("activity_after_reset", g, cnt[g], 0);

        // Fresh copy after the reset
        run_copy(8'h03, 8'h60, 9'd4, 0);
        check_run(0, 4, 3, 6, 7);
        check_run(1, 4, 5, 8, 9);
        for (int g = 0; g < 2; g++) begin
            check("ram_60", g, int'(ram[g][8'h60]), 8'hA6);
            check("ram_61", g, int'(ram[g][8'h61]), 8'hA1);
            check("ram_62", g, int'(ram[g][8'h62]), 8'hA0);
            check("ram_63", g, int'(ram[g][8'h63]), 8'hA3);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
